// File: rtl/car_sensor_conditioner.sv
// rtl/car_sensor_conditioner.sv - loop-detector conditioning per lane: sync, debounce, queue count, stuck-loop fault
// Turns raw asynchronous loop signals into clean carA/carB requests for the traffic-light controller.
module car_sensor_conditioner #(
  parameter int DB_CYCLES    = 4,
  parameter int CW           = 3,
  parameter int STUCK_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sensA_raw,
  input  logic          sensB_raw,
  input  logic [2:0]    lightA,
  input  logic [2:0]    lightB,
  output logic          carA,
  output logic          carB,
  output logic [CW-1:0] cntA,
  output logic [CW-1:0] cntB,
  output logic          faultA,
  output logic          faultB
);

  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int SKW = $clog2(STUCK_CYCLES);
  localparam logic [DBW-1:0] DB_MAX   = DBW'(DB_CYCLES - 1);
  localparam logic [SKW-1:0] STK_MAX  = SKW'(STUCK_CYCLES - 1);
  localparam logic [SKW-1:0] STK_PRE  = SKW'(STUCK_CYCLES - 2);
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [2:0]     LT_GREEN  = 3'b001;
  localparam logic [2:0]     LT_YELLOW = 3'b010;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic           w_raw;
    logic [2:0]     w_light;
    logic           w_rise;
    logic           w_fall;
    logic           w_served;
    logic           r_s1;
    logic           r_s2;
    logic           r_deb;
    logic           r_deb_d;
    logic           r_fault;
    logic [DBW-1:0] r_dbc;
    logic [SKW-1:0] r_stk;
    logic [CW-1:0]  r_cnt;

    assign w_raw    = (l == 0) ? sensA_raw : sensB_raw;
    assign w_light  = (l == 0) ? lightA : lightB;
    assign w_rise   = r_deb & ~r_deb_d;
    assign w_fall   = ~r_deb & r_deb_d;
    // Anything other than a clean GREEN/YELLOW is treated as RED: no departure.
    assign w_served = (w_light == LT_GREEN) || (w_light == LT_YELLOW);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_dbc   <= '0;
      end else begin
        r_s1    <= w_raw;
        r_s2    <= r_s1;
        r_deb_d <= r_deb;
        if (r_s2 == r_deb) begin
          r_dbc <= '0;
        end else if (r_dbc == DB_MAX) begin
          r_deb <= r_s2;
          r_dbc <= '0;
        end else begin
          r_dbc <= r_dbc + 1'b1;
        end
      end
    end

    // Fault is raised on the same edge the stuck counter reaches its terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stk   <= '0;
        r_fault <= 1'b0;
      end else if (!r_deb) begin
        r_stk   <= '0;
        r_fault <= 1'b0;
      end else if (r_stk != STK_MAX) begin
        r_stk <= r_stk + 1'b1;
        if (r_stk == STK_PRE) begin
          r_fault <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (!r_fault) begin
        if (w_rise && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_fall && w_served && (r_cnt != '0)) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign cntA   = g_lane[0].r_cnt;
  assign cntB   = g_lane[1].r_cnt;
  assign faultA = g_lane[0].r_fault;
  assign faultB = g_lane[1].r_fault;
  assign carA   = (cntA != '0) | faultA;
  assign carB   = (cntB != '0) | faultB;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// tb/tb_car_sensor_conditioner.sv - self-checking bench for car_sensor_conditioner
module tb_car_sensor_conditioner;

  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int STUCK = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sensA_raw = 1'b0;
  logic          sensB_raw = 1'b0;
  logic [2:0]    lightA = 3'b100;
  logic [2:0]    lightB = 3'b100;
  logic          carA, carB, faultA, faultB;
  logic [CW-1:0] cntA, cntB;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  car_sensor_conditioner #(.DB_CYCLES(4), .CW(CW), .STUCK_CYCLES(STUCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .sensA_raw(sensA_raw), .sensB_raw(sensB_raw),
    .lightA(lightA), .lightB(lightB),
    .carA(carA), .carB(carB),
    .cntA(cntA), .cntB(cntB),
    .faultA(faultA), .faultB(faultB)
  );

  // Model: raw history per edge; the debounced level flips once the synced value
  // (raw two edges back) has disagreed with it on four consecutive edges.
  logic [5:0] m_hist [2];
  logic       m_deb  [2];
  logic       m_rise [2];
  logic       m_fall [2];
  logic       m_fault[2];
  int         m_run  [2];
  int         m_cnt  [2];
  logic       m_raw;
  logic [2:0] m_lt;

  always @(posedge clk or negedge rst_n) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        m_hist[l] = '0; m_deb[l] = 1'b0; m_rise[l] = 1'b0; m_fall[l] = 1'b0;
        m_fault[l] = 1'b0; m_run[l] = 0; m_cnt[l] = 0;
      end else begin
        m_raw = (l == 0) ? sensA_raw : sensB_raw;
        m_lt  = (l == 0) ? lightA : lightB;
        if (!m_fault[l]) begin
          if (m_rise[l])
            m_cnt[l] = (m_cnt[l] < CMAX) ? m_cnt[l] + 1 : CMAX;
          else if (m_fall[l] && (m_lt == 3'b001 || m_lt == 3'b010))
            m_cnt[l] = (m_cnt[l] > 0) ? m_cnt[l] - 1 : 0;
        end
        m_run[l]   = m_deb[l] ? m_run[l] + 1 : 0;
        m_fault[l] = (m_run[l] >= STUCK - 1);
        m_hist[l]  = {m_hist[l][4:0], m_raw};
        m_rise[l]  = 1'b0;
        m_fall[l]  = 1'b0;
        if (m_hist[l][5:2] == {4{~m_deb[l]}}) begin
          m_deb[l]  = ~m_deb[l];
          m_rise[l] = m_deb[l];
          m_fall[l] = ~m_deb[l];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #4;
    if (rst_n) begin
      chk("model cntA",   32'(cntA),   32'(m_cnt[0]));
      chk("model cntB",   32'(cntB),   32'(m_cnt[1]));
      chk("model faultA", 32'(faultA), 32'(m_fault[0]));
      chk("model faultB", 32'(faultB), 32'(m_fault[1]));
      chk("model carA",   32'(carA),   32'((m_cnt[0] != 0) || m_fault[0]));
      chk("model carB",   32'(carB),   32'((m_cnt[1] != 0) || m_fault[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input int hi, input int lo);
    sensA_raw = 1'b1; tick(hi);
    sensA_raw = 1'b0; tick(lo);
  endtask

  initial begin
    tick(3);
    chk("reset carA", 32'(carA), 0);
    chk("reset cntA", 32'(cntA), 0);
    chk("reset faultA", 32'(faultA), 0);
    chk("reset carB", 32'(carB), 0);
    rst_n = 1'b1;
    tick(2);

    // Held arrival under RED: request exactly seven edges after the input changes.
    sensA_raw = 1'b1;
    tick(6);
    chk("lat carA early", 32'(carA), 0);
    tick(1);
    chk("lat carA", 32'(carA), 1);
    chk("lat cntA", 32'(cntA), 1);
    chk("lat carB", 32'(carB), 0);

    // Short glitch on B never passes the debouncer.
    sensB_raw = 1'b1; tick(3);
    sensB_raw = 1'b0; tick(10);
    chk("glitch cntB", 32'(cntB), 0);
    chk("glitch carB", 32'(carB), 0);

    // Fall under RED is ignored, then saturate without wrap, then a GREEN departure.
    sensA_raw = 1'b0; tick(10);
    chk("red fall cntA", 32'(cntA), 1);
    for (int i = 0; i < 8; i++) pulse_a(10, 10);
    chk("sat cntA", 32'(cntA), 7);
    lightA = 3'b001;
    pulse_a(10, 10);
    chk("green depart cntA", 32'(cntA), 6);
    lightA = 3'b011;
    pulse_a(10, 10);
    chk("non-onehot as red cntA", 32'(cntA), 7);

    // Lane B: rise, RED fall, rise, then GREEN fall.
    sensB_raw = 1'b1; tick(10);
    sensB_raw = 1'b0; tick(10);
    chk("B red fall cntB", 32'(cntB), 1);
    sensB_raw = 1'b1; tick(10);
    chk("B second rise cntB", 32'(cntB), 2);
    chk("B carB", 32'(carB), 1);
    lightB = 3'b001;
    sensB_raw = 1'b0; tick(10);
    chk("B green fall cntB", 32'(cntB), 1);

    // Stuck loop: fault on debounced-high cycle 64, count frozen through release.
    lightA = 3'b100;
    sensA_raw = 1'b1;
    tick(68);
    chk("stuck pre faultA", 32'(faultA), 0);
    tick(1);
    chk("stuck faultA", 32'(faultA), 1);
    chk("stuck carA", 32'(carA), 1);
    chk("stuck cntA", 32'(cntA), 7);
    tick(11);
    lightA = 3'b001;
    sensA_raw = 1'b0;
    tick(6);
    chk("release faultA held", 32'(faultA), 1);
    tick(1);
    chk("release faultA", 32'(faultA), 0);
    chk("frozen cntA", 32'(cntA), 7);

    // Reset mid-count and mid-debounce, then full latency again.
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    lightA = 3'b100;
    for (int i = 0; i < 3; i++) pulse_a(10, 10);
    chk("pre-reset cntA", 32'(cntA), 3);
    sensA_raw = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("async rst cntA", 32'(cntA), 0);
    chk("async rst carA", 32'(carA), 0);
    chk("async rst faultA", 32'(faultA), 0);
    chk("async rst cntB", 32'(cntB), 0);
    chk("async rst carB", 32'(carB), 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post-rst carA early", 32'(carA), 0);
    tick(1);
    chk("post-rst carA", 32'(carA), 1);
    chk("post-rst cntA", 32'(cntA), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
